// File: rtl/clk_reset_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
// Imported by the sequencer top and reusable by neighbouring clock/reset logic.
package clk_reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2
    } seq_state_e;

    localparam int unsigned RELOCK_W = 8;

    // One spare bit above the larger terminal count keeps the exact compares unambiguous.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return w + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with synchronous active-low clear.
// Output settles two destination-clock edges after the input changes.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/clk_reset_sequencer.sv
// Qualifies MMCM lock, then releases active-high resets one stage at a time (bit 0 first).
// Any loss of lock re-asserts every stage and bumps a saturating relock counter.
module clk_reset_sequencer
    import clk_reset_seq_pkg::*;
#(
    parameter int unsigned STAGES      = 3,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned STAGE_GAP   = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_locked,
    output logic [STAGES-1:0]   o_rst,
    output logic                o_ready,
    output logic [RELOCK_W-1:0] o_relock_cnt
);

    localparam int unsigned CW = cnt_width(LOCK_CYCLES, STAGE_GAP);
    localparam int unsigned IW = $clog2(STAGES) + 1;

    localparam logic [CW-1:0] LOCK_TC  = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] GAP_TC   = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(STAGES - 1);

    seq_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [STAGES-1:0]   rst_q, rst_d;
    logic                ready_q, ready_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                locked_s;

    sync_2ff u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_locked),
        .o_q     (locked_s)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            idx_q    <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            relock_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rst_q    <= rst_d;
            ready_q  <= ready_d;
            relock_q <= relock_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rst_d    = rst_q;
        ready_d  = ready_q;
        relock_d = relock_q;

        unique case (state_q)
            WAIT_LOCK: begin
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_TC) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            RELEASE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                    if (relock_q != '1) begin
                        relock_d = relock_q + RELOCK_W'(1);
                    end
                end else if (cnt_q == GAP_TC) begin
                    // Released bits form a contiguous low run from bit 0, so
                    // shifting in a zero clears exactly bit idx_q.
                    rst_d = rst_q << 1;
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                    if (relock_q != '1) begin
                        relock_d = relock_q + RELOCK_W'(1);
                    end
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                rst_d   = '1;
                ready_d = 1'b0;
            end
        endcase
    end

    assign o_rst        = rst_q;
    assign o_ready      = ready_q;
    assign o_relock_cnt = relock_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Directed bench for clk_reset_sequencer: a 3-stage (8/4) instance and a 1-stage (1/1) instance.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_clk_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic [2:0] o_rst;
    logic       o_ready;
    logic [7:0] o_relock;

    logic       rst1_n;
    logic       locked1;
    logic [0:0] o_rst1;
    logic       o_ready1;
    logic [7:0] o_relock1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_reset_sequencer #(
        .STAGES      (3),
        .LOCK_CYCLES (8),
        .STAGE_GAP   (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_locked     (locked),
        .o_rst        (o_rst),
        .o_ready      (o_ready),
        .o_relock_cnt (o_relock)
    );

    clk_reset_sequencer #(
        .STAGES      (1),
        .LOCK_CYCLES (1),
        .STAGE_GAP   (1)
    ) dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst1_n),
        .i_locked     (locked1),
        .o_rst        (o_rst1),
        .o_ready      (o_ready1),
        .o_relock_cnt (o_relock1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        locked = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (o_rst !== 3'b111) begin
            failures++;
            $display("FAIL reset_rst got=%b exp=%b", o_rst, 3'b111);
        end
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=%b", o_ready, 1'b0);
        end
        checks++;
        if (o_relock !== 8'd0) begin
            failures++;
            $display("FAIL reset_relock got=%0d exp=%0d", o_relock, 0);
        end
    endtask

    // Lock applied before edge 1: 110 after edge 14, 100 after 18, 000 + ready after 22.
    task automatic test_basic_sequence(input logic [7:0] exp_relock);
        logic [2:0] exp_rst;
        logic       exp_rdy;
        rst_n  = 1'b1;
        locked = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            exp_rst = (c < 14) ? 3'b111 : (c < 18) ? 3'b110 : (c < 22) ? 3'b100 : 3'b000;
            exp_rdy = (c >= 22);
            checks++;
            if (o_rst !== exp_rst || o_ready !== exp_rdy || o_relock !== exp_relock) begin
                failures++;
                $display("FAIL basic c=%0d got rst=%b rdy=%b relock=%0d exp rst=%b rdy=%b relock=%0d",
                         c, o_rst, o_ready, o_relock, exp_rst, exp_rdy, exp_relock);
            end
        end
    endtask

    // Drop lock for one cycle while cnt==5; qualification restarts from edge 10.
    task automatic test_glitch();
        logic [2:0] exp_rst;
        logic       exp_rdy;
        apply_reset();
        rst_n  = 1'b1;
        locked = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            tick();
            exp_rst = (c < 22) ? 3'b111 : (c < 26) ? 3'b110 : (c < 30) ? 3'b100 : 3'b000;
            exp_rdy = (c >= 30);
            checks++;
            if (o_rst !== exp_rst || o_ready !== exp_rdy || o_relock !== 8'd0) begin
                failures++;
                $display("FAIL glitch c=%0d got rst=%b rdy=%b relock=%0d exp rst=%b rdy=%b relock=0",
                         c, o_rst, o_ready, o_relock, exp_rst, exp_rdy);
            end
            if (c == 7) locked = 1'b0;
            if (c == 8) locked = 1'b1;
        end
    endtask

    task automatic test_lock_loss_run();
        logic [2:0] exp_rst;
        logic       exp_rdy;
        logic [7:0] exp_rl;
        locked = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_rst = (c < 3) ? 3'b000 : 3'b111;
            exp_rdy = (c < 3);
            exp_rl  = (c < 3) ? 8'd0 : 8'd1;
            checks++;
            if (o_rst !== exp_rst || o_ready !== exp_rdy || o_relock !== exp_rl) begin
                failures++;
                $display("FAIL loss_run c=%0d got rst=%b rdy=%b relock=%0d exp rst=%b rdy=%b relock=%0d",
                         c, o_rst, o_ready, o_relock, exp_rst, exp_rdy, exp_rl);
            end
        end
        test_basic_sequence(8'd1);
    endtask

    task automatic test_loss_mid_release();
        logic [2:0] exp_rst;
        logic [7:0] exp_rl;
        apply_reset();
        rst_n  = 1'b1;
        locked = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp_rst = (c < 14) ? 3'b111 : (c < 17) ? 3'b110 : 3'b111;
            exp_rl  = (c < 17) ? 8'd0 : 8'd1;
            checks++;
            if (o_rst !== exp_rst || o_ready !== 1'b0 || o_relock !== exp_rl) begin
                failures++;
                $display("FAIL loss_mid c=%0d got rst=%b rdy=%b relock=%0d exp rst=%b rdy=0 relock=%0d",
                         c, o_rst, o_ready, o_relock, exp_rst, exp_rl);
            end
            if (c == 14) locked = 1'b0;
        end
        test_basic_sequence(8'd1);
    endtask

    // Each event: 11 cycles locked (reaches RELEASE), then 3 cycles unlocked.
    task automatic test_reset_saturation();
        logic [7:0] exp_rl;
        rst_n = 1'b0;
        tick();
        checks++;
        if (o_rst !== 3'b111 || o_ready !== 1'b0 || o_relock !== 8'd0) begin
            failures++;
            $display("FAIL reset_in_run got rst=%b rdy=%b relock=%0d exp rst=111 rdy=0 relock=0",
                     o_rst, o_ready, o_relock);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            locked = 1'b1;
            repeat (11) tick();
            locked = 1'b0;
            repeat (3) tick();
            exp_rl = (n < 255) ? n[7:0] : 8'hFF;
            if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
                checks++;
                if (o_relock !== exp_rl || o_rst !== 3'b111) begin
                    failures++;
                    $display("FAIL saturate n=%0d got relock=%0d rst=%b exp relock=%0d rst=111",
                             n, o_relock, o_rst, exp_rl);
                end
            end
        end
    endtask

    task automatic test_single_stage();
        logic exp_rst;
        logic exp_rdy;
        rst1_n  = 1'b0;
        locked1 = 1'b0;
        tick();
        tick();
        checks++;
        if (o_rst1 !== 1'b1 || o_ready1 !== 1'b0 || o_relock1 !== 8'd0) begin
            failures++;
            $display("FAIL single_reset got rst=%b rdy=%b relock=%0d exp rst=1 rdy=0 relock=0",
                     o_rst1, o_ready1, o_relock1);
        end
        rst1_n  = 1'b1;
        locked1 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_rst = (c < 4);
            exp_rdy = (c >= 4);
            checks++;
            if (o_rst1 !== exp_rst || o_ready1 !== exp_rdy) begin
                failures++;
                $display("FAIL single_release c=%0d got rst=%b rdy=%b exp rst=%b rdy=%b",
                         c, o_rst1, o_ready1, exp_rst, exp_rdy);
            end
        end
        locked1 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            exp_rst = (c >= 3);
            exp_rdy = (c < 3);
            checks++;
            if (o_rst1 !== exp_rst || o_ready1 !== exp_rdy || o_relock1 !== ((c >= 3) ? 8'd1 : 8'd0)) begin
                failures++;
                $display("FAIL single_loss c=%0d got rst=%b rdy=%b relock=%0d exp rst=%b rdy=%b",
                         c, o_rst1, o_ready1, o_relock1, exp_rst, exp_rdy);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        locked  = 1'b0;
        rst1_n  = 1'b0;
        locked1 = 1'b0;
        test_reset();
        test_basic_sequence(8'd0);
        test_glitch();
        test_lock_loss_run();
        test_loss_mid_release();
        test_reset_saturation();
        test_single_stage();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
